// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, bridge state type and byte-lane helper for the
// AHB-to-SRAM bridge with posted write buffer.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_QWORD = 3'd4
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    // Little-endian lane mask for a transfer of 2**size bytes starting at addr_lsbs.
    // Wide enough for the largest legal bus (128 bits, 16 lanes).
    function automatic logic [15:0] be_from_size(input logic [2:0] size,
                                                 input logic [3:0] addr_lsbs);
        logic [31:0] ones;
        ones = (32'd1 << (32'd1 << size)) - 32'd1;
        return 16'(ones << addr_lsbs);
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry posted write buffer: captures a write, releases it on SRAM grant,
// and overlays its bytes onto SRAM read data for read-after-write forwarding.
module ahb_sram_wbuf
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 14,
    localparam int NB        = DATA_WIDTH / 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cap,
    input  logic [AW-1:0]         cap_addr,
    input  logic [NB-1:0]         cap_be,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  drain_gnt,
    input  logic [AW-1:0]         fwd_addr,
    input  logic [DATA_WIDTH-1:0] fwd_rdata,
    output logic                  vld,
    output logic [AW-1:0]         addr,
    output logic [NB-1:0]         be,
    output logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    logic hit;

    // A capture in the same cycle as a grant replaces the draining entry.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            vld <= 1'b0;
        end else if (cap) begin
            vld <= 1'b1;
        end else if (drain_gnt) begin
            vld <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (cap) begin
            addr <= cap_addr;
            be   <= cap_be;
            data <= cap_data;
        end
    end

    assign hit = vld && (addr == fwd_addr);

    always_comb begin
        fwd_data = fwd_rdata;
        for (int i = 0; i < NB; i++) begin
            if (hit && be[i]) begin
                fwd_data[8*i +: 8] = data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_sram_bridge_wb.sv
// AHB-Lite slave in front of a single-port word-addressed SRAM, with a posted
// write buffer, grant-driven wait states and two-cycle ERROR responses.
module ahb_sram_bridge_wb
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_BYTES    = 65536,
    parameter int HBURST_WIDTH = 3,
    parameter int HPROT_WIDTH  = 4,
    localparam int NB          = DATA_WIDTH / 8,
    localparam int LSB         = $clog2(NB),
    localparam int AW          = $clog2(MEM_BYTES) - LSB
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [HBURST_WIDTH-1:0] HBURST,
    input  logic [HPROT_WIDTH-1:0]  HPROT,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic                    HREADY,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic                    sram_req,
    output logic                    sram_we,
    output logic [AW-1:0]           sram_addr,
    output logic [NB-1:0]           sram_be,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic                    sram_gnt,
    input  logic [DATA_WIDTH-1:0]   sram_rdata
);

    bridge_state_e         state_q, state_d;

    logic                  accept;
    logic                  addr_err;
    logic [LSB-1:0]        size_mask;
    logic [AW-1:0]         word_addr;
    logic [NB-1:0]         be_a;

    logic                  wr_vld_p1;
    logic [AW-1:0]         addr_p1;
    logic [NB-1:0]         be_p1;
    logic [DATA_WIDTH-1:0] hrdata_q;

    logic                  rd_sel;
    logic                  drain_sel;
    logic                  drain_gnt;
    logic                  wr_stall;
    logic                  capture;

    logic                  buf_vld;
    logic [AW-1:0]         buf_addr;
    logic [NB-1:0]         buf_be;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [DATA_WIDTH-1:0] fwd_data;

    logic                  unused_inputs;
    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT};

    // Address phase: decode, error check and lane mask
    assign accept    = HSEL && HREADY && HTRANS[1];
    assign size_mask = LSB'((32'd1 << HSIZE) - 32'd1);
    assign addr_err  = (HADDR >= ADDR_WIDTH'(MEM_BYTES))
                    || (32'(HSIZE) > LSB)
                    || ((HADDR[LSB-1:0] & size_mask) != '0);
    assign word_addr = HADDR[LSB +: AW];
    assign be_a      = NB'(be_from_size(HSIZE, 4'(HADDR[LSB-1:0])));

    // Data phase: SRAM arbitration, wait states and capture
    assign rd_sel    = (state_q == ST_RD_REQ);
    assign drain_sel = buf_vld && !rd_sel && !HRESET;
    assign drain_gnt = drain_sel && sram_gnt;
    assign wr_stall  = wr_vld_p1 && buf_vld && !drain_gnt;
    assign capture   = wr_vld_p1 && !wr_stall;

    assign sram_req   = !HRESET && (rd_sel || buf_vld);
    assign sram_we    = drain_sel;
    assign sram_addr  = rd_sel ? addr_p1 : buf_addr;
    assign sram_be    = rd_sel ? {NB{1'b1}} : buf_be;
    assign sram_wdata = buf_data;

    assign HREADYOUT = !(rd_sel || (state_q == ST_ERR1) || wr_stall);
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign HRDATA    = (state_q == ST_RD_DATA) ? fwd_data : hrdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RD_REQ: begin
                if (sram_gnt) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (!accept) begin
                    state_d = ST_IDLE;
                end else if (addr_err) begin
                    state_d = ST_ERR1;
                end else if (!HWRITE) begin
                    state_d = ST_RD_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            wr_vld_p1 <= 1'b0;
            hrdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_vld_p1 <= HWRITE && !addr_err;
            end else if (capture) begin
                wr_vld_p1 <= 1'b0;
            end
            if (state_q == ST_RD_DATA) begin
                hrdata_q <= fwd_data;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept) begin
            addr_p1 <= word_addr;
            be_p1   <= be_a;
        end
    end

    ahb_sram_wbuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_wbuf (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cap       (capture),
        .cap_addr  (addr_p1),
        .cap_be    (be_p1),
        .cap_data  (HWDATA),
        .drain_gnt (drain_gnt),
        .fwd_addr  (addr_p1),
        .fwd_rdata (sram_rdata),
        .vld       (buf_vld),
        .addr      (buf_addr),
        .be        (buf_be),
        .data      (buf_data),
        .fwd_data  (fwd_data)
    );

endmodule

// File: tb/tb_ahb_sram_bridge_wb.sv
// Bench for ahb_sram_bridge_wb: directed scenarios plus randomized traffic
// against a byte-accurate memory image and an SRAM responder model.
`timescale 1ns/1ps
module tb_ahb_sram_bridge_wb;

    localparam int AW    = 14;
    localparam int WORDS = 16384;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = '0;
    logic [2:0]  HBURST = '0;
    logic [3:0]  HPROT = '0;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP;
    logic        sram_req, sram_we, sram_gnt;
    logic [AW-1:0] sram_addr;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata, sram_rdata;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahb_sram_bridge_wb dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_be(sram_be),
        .sram_wdata(sram_wdata), .sram_gnt(sram_gnt), .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // ---------------- SRAM responder model ----------------
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   data;
    } op_t;

    logic [31:0] mem [0:WORDS-1];
    bit          mem_init = 1'b0;
    op_t         oplog[$];
    int          req_wait = 0;
    bit          rnd_bit = 1'b0;
    bit          gnt_rand = 1'b0;
    int          gnt_delay = 0;
    logic [31:0] rdata_q = '0;

    assign sram_gnt   = sram_req && (gnt_rand ? rnd_bit : (req_wait >= gnt_delay));
    assign sram_rdata = rdata_q;

    always @(posedge HCLK) begin
        if (!mem_init) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end
        rnd_bit <= 1'($urandom_range(0, 1));
        if (sram_req && !sram_gnt) req_wait <= req_wait + 1;
        else req_wait <= 0;
        if (sram_req && sram_gnt) begin
            oplog.push_back({sram_we, sram_addr, sram_be, sram_we ? sram_wdata : mem[sram_addr]});
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                rdata_q <= mem[sram_addr];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- reference memory and AHB master ----------------
    typedef struct packed {
        bit          idle;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic [31:0] gold [0:WORDS-1];
    xfer_t       xq[$];
    int          wait_log[$];
    int          ncmp = 0, nfail = 0;
    int          err_req_cnt = 0, req_stall_cnt = 0;
    bit          abort = 1'b0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] addr, input logic [2:0] size);
        int nbytes;
        nbytes = 1 << size;
        return (addr >= 32'h10000) || (size > 3'd2) || ((addr % nbytes) != 0);
    endfunction

    task automatic apply_write(input xfer_t x);
        int lane;
        for (int k = 0; k < (1 << x.size); k++) begin
            lane = int'(x.addr[1:0]) + k;
            gold[x.addr[15:2]][8*lane +: 8] = x.wdata[8*lane +: 8];
        end
    endtask

    task automatic push(input bit idle, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata);
        xq.push_back({idle, wr, addr, size, wdata});
    endtask

    task automatic idle_cycles(input int n);
        HSEL = 1'b0; HTRANS = 2'b00;
        repeat (n) begin @(posedge HCLK); #1; end
    endtask

    // Pipelined master: address phase of the next transfer overlaps the data phase of the current.
    task automatic run_xq();
        xfer_t cur, dp;
        bit    dp_v, dp_err, ready;
        int    waits;
        dp_v = 0; dp_err = 0; waits = 0; cur = '0; dp = '0;
        while ((xq.size() > 0 || dp_v) && !abort) begin
            if (xq.size() > 0) begin
                cur = xq[0];
                HSEL = 1'b1; HTRANS = cur.idle ? 2'b00 : 2'b10;
                HADDR = cur.addr; HWRITE = cur.wr; HSIZE = cur.size;
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00;
            end
            HWDATA = (dp_v && dp.wr) ? dp.wdata : 32'h0;
            @(negedge HCLK);
            ready = HREADYOUT;
            if (dp_v && dp_err) begin
                chk("err_hresp", 64'(HRESP), 64'd1);
                if (sram_req && !sram_we) err_req_cnt++;
            end
            if (!ready) begin
                waits++;
                if (sram_req) req_stall_cnt++;
                if (waits > 60) begin
                    ncmp++; nfail++;
                    $error("FAIL hready_timeout: observed=%0d wait cycles expected<=60", waits);
                    abort = 1'b1;
                end
            end else if (dp_v) begin
                if (dp_err) begin
                    chk("err_waits", 64'(waits), 64'd1);
                end else begin
                    chk("okay_hresp", 64'(HRESP), 64'd0);
                    if (dp.wr) apply_write(dp);
                    else begin
                        last_rd = HRDATA;
                        chk("rdata", 64'(HRDATA), 64'(gold[dp.addr[15:2]]));
                    end
                end
                wait_log.push_back(waits);
            end
            if (ready) begin
                dp_v = 0;
                waits = 0;
                if (xq.size() > 0) begin
                    cur = xq.pop_front();
                    dp = cur; dp_v = !cur.idle; dp_err = is_err(cur.addr, cur.size);
                end
            end
            @(posedge HCLK); #1;
        end
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    initial begin
        int s_op, s_w, idx, cnt, mism;
        logic [31:0] a;
        logic [2:0]  sz;

        for (int i = 0; i < WORDS; i++) gold[i] = init_word(i);

        // Reset
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("rst_hresp", 64'(HRESP), 64'd0);
        chk("rst_hrdata", 64'(HRDATA), 64'd0);
        chk("rst_sram_req", 64'(sram_req), 64'd0);
        @(posedge HCLK); #1;

        // Read-after-write forwarding, read request before drain
        s_op = oplog.size(); s_w = wait_log.size();
        push(0, 1, 32'h100, 3'd2, 32'hDEADBEEF);
        push(0, 0, 32'h100, 3'd2, 32'h0);
        run_xq(); idle_cycles(3);
        chk("t1_rdata", 64'(last_rd), 64'hDEADBEEF);
        chk("t1_rd_waits", 64'(wait_log[s_w+1]), 64'd1);
        chk("t1_op0_read", 64'({oplog[s_op].we, oplog[s_op].addr}), 64'({1'b0, 14'h40}));
        chk("t1_op1_write", 64'({oplog[s_op+1].we, oplog[s_op+1].addr, oplog[s_op+1].data}),
            64'({1'b1, 14'h40, 32'hDEADBEEF}));

        // Byte write merged into an existing word
        push(0, 1, 32'h100, 3'd2, 32'h11223344);
        run_xq(); idle_cycles(3);
        s_op = oplog.size();
        push(0, 1, 32'h103, 3'd0, 32'hAA000000);
        push(0, 0, 32'h100, 3'd2, 32'h0);
        run_xq(); idle_cycles(3);
        idx = -1;
        for (int k = s_op; k < oplog.size(); k++) if (oplog[k].we && idx < 0) idx = k;
        chk("t2_drain_be", 64'((idx >= 0) ? oplog[idx].be : 4'hx), 64'h8);
        chk("t2_rdata", 64'(last_rd), 64'hAA223344);
        chk("t2_mem", 64'(mem[14'h40]), 64'hAA223344);

        // Read with grant held off three cycles
        gnt_delay = 3; req_stall_cnt = 0;
        s_op = oplog.size(); s_w = wait_log.size();
        push(0, 0, 32'h200, 3'd2, 32'h0);
        run_xq(); idle_cycles(2);
        chk("t3_waits", 64'(wait_log[s_w]), 64'd4);
        chk("t3_req_held", 64'(req_stall_cnt), 64'd4);
        cnt = 0;
        for (int k = s_op; k < oplog.size(); k++) if (!oplog[k].we) cnt++;
        chk("t3_single_read", 64'(cnt), 64'd1);
        chk("t3_rdata", 64'(last_rd), 64'(init_word(32'h80)));

        // Error responses: out of range and misaligned
        gnt_delay = 0; err_req_cnt = 0;
        s_op = oplog.size(); s_w = wait_log.size();
        push(0, 0, 32'h10000, 3'd2, 32'h0);
        push(0, 0, 32'h101, 3'd1, 32'h0);
        run_xq(); idle_cycles(2);
        chk("t4_range_waits", 64'(wait_log[s_w]), 64'd1);
        chk("t4_align_waits", 64'(wait_log[s_w+1]), 64'd1);
        chk("t4_no_sram", 64'(oplog.size() - s_op), 64'd0);
        chk("t4_err_req", 64'(err_req_cnt), 64'd0);

        // Back-to-back writes stall on a slow drain
        gnt_delay = 2;
        s_op = oplog.size(); s_w = wait_log.size();
        push(0, 1, 32'h180, 3'd2, 32'hA5A5_0001);
        push(0, 1, 32'h184, 3'd2, 32'h5A5A_0002);
        run_xq(); idle_cycles(8);
        chk("t5_first_waits", 64'(wait_log[s_w]), 64'd0);
        chk("t5_second_waits", 64'(wait_log[s_w+1]), 64'd2);
        chk("t5_order0", 64'({oplog[s_op].we, oplog[s_op].addr, oplog[s_op].data}),
            64'({1'b1, 14'h60, 32'hA5A5_0001}));
        chk("t5_order1", 64'({oplog[s_op+1].we, oplog[s_op+1].addr, oplog[s_op+1].data}),
            64'({1'b1, 14'h61, 32'h5A5A_0002}));

        // Reset while a read waits and a write is buffered
        gnt_delay = 10;
        s_op = oplog.size();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h300; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HADDR = 32'h304; HWRITE = 1'b0; HWDATA = 32'h55AA55AA;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        chk("t6_rdreq_hready", 64'(HREADYOUT), 64'd0);
        chk("t6_rdreq_req", 64'({sram_req, sram_we}), 64'b10);
        @(posedge HCLK); #1 HRESET = 1'b1;
        @(posedge HCLK); #1 HRESET = 1'b0;
        @(negedge HCLK);
        chk("t6_post_hready", 64'(HREADYOUT), 64'd1);
        chk("t6_post_hresp", 64'(HRESP), 64'd0);
        chk("t6_post_req", 64'(sram_req), 64'd0);
        chk("t6_post_hrdata", 64'(HRDATA), 64'd0);
        @(posedge HCLK); #1;
        gnt_delay = 0;
        idle_cycles(10);
        cnt = 0;
        for (int k = s_op; k < oplog.size(); k++) if (oplog[k].we) cnt++;
        chk("t6_no_drain", 64'(cnt), 64'd0);
        chk("t6_mem_kept", 64'(mem[14'hC0]), 64'(init_word(32'hC0)));

        // Randomized traffic with random grants
        gnt_rand = 1'b1; err_req_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                push(1, 0, 32'h0, 3'd0, 32'h0);
            end else begin
                sz = 3'($urandom_range(0, 2));
                a  = (32'($urandom_range(0, 255)) << 2) | (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 1));
                case ($urandom_range(0, 24))
                    0: a = 32'h10000 + (a & 32'hFFC);
                    1: begin sz = 3'd2; a = a | 32'd1; end
                    2: sz = 3'd3;
                    default: ;
                endcase
                push(0, 1'($urandom_range(0, 1)), a, sz, $urandom);
            end
        end
        run_xq();
        gnt_rand = 1'b0;
        idle_cycles(10);
        chk("t7_err_req", 64'(err_req_cnt), 64'd0);
        mism = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== gold[i]) mism++;
        chk("t7_final_mem", 64'(mism), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/ahb_sram_bridge_wb.md
Name: ahb_sram_bridge_wb

Overview:
- Parametrised AHB-Lite slave bridging to a single-port, word-addressed SRAM macro; successor to the current AHB-to-SRAM bridge.
- Adds: generic byte lanes for any DATA_WIDTH, one-entry posted write buffer with read-after-write forwarding, slave wait states driven by SRAM grant, and two-cycle ERROR responses.
- Sits between the AHB interconnect (HSEL/HREADY) and one SRAM bank.

Parameters:
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, bus and SRAM word width; legal values 32, 64, 128
MEM_BYTES, 65536, implemented memory size in bytes; must be a power of two
HBURST_WIDTH, 3, HBURST width; bursts are handled as a sequence of single transfers
HPROT_WIDTH, 4, HPROT width; HPROT is ignored

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous, active-high reset
HSEL  in  1  slave select
HADDR  in  ADDR_WIDTH  address
HTRANS  in  2  transfer type
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HBURST  in  HBURST_WIDTH  ignored
HPROT  in  HPROT_WIDTH  ignored
HWDATA  in  DATA_WIDTH  write data (data phase)
HREADY  in  1  bus ready
HRDATA  out  DATA_WIDTH  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  1 = ERROR
sram_req  out  1  access request
sram_we  out  1  1 = write
sram_addr  out  AW  word address; AW = log2(MEM_BYTES) - log2(DATA_WIDTH/8)
sram_be  out  DATA_WIDTH/8  byte enables
sram_wdata  out  DATA_WIDTH  write data
sram_gnt  in  1  request accepted this cycle
sram_rdata  in  DATA_WIDTH  valid the cycle after a granted read

Behaviour:
- Clock and reset: one clock, HCLK. HRESET is synchronous and active-high.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, sram_req=0, sram_we=0, FSM in IDLE, write buffer empty.
- Reset mid-operation: a pending read is abandoned and a buffered write is discarded; no SRAM request is issued in the cycle after reset.
- Address-phase accept: HSEL && HREADY && HTRANS[1]. IDLE/BUSY transfers, or HSEL=0, get zero-wait OKAY.
- Error conditions: HADDR >= MEM_BYTES, or HSIZE > log2(DATA_WIDTH/8), or HADDR not aligned to HSIZE.
  - FSM goes ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1).
  - No SRAM access and no buffer update.
- Byte enables: be = ((1<<(1<<HSIZE))-1) << HADDR[log2(DATA_WIDTH/8)-1:0]. Little-endian lanes.
- Write, address phase: latch word address and be.
- Write, data phase:
  - Buffer empty, or draining with sram_gnt this cycle: HREADYOUT=1, and HWDATA is captured into the buffer at cycle end.
  - Otherwise: HREADYOUT=0 until the old entry drains.
- Drain: while the buffer is valid and the FSM is not in RD_REQ, assert sram_req=1, sram_we=1 with the buffer's addr/be/data. Entry clears on sram_gnt.
- Read FSM: IDLE -> RD_REQ -> RD_DATA -> IDLE (or back to RD_REQ/ERR1 on a new accepted transfer).
  - RD_REQ: sram_req=1, sram_we=0; read has priority over drain. HREADYOUT=0. Stay until sram_gnt.
  - RD_DATA: HRDATA = per byte, buffer data where buffer valid, address matches and be set, else sram_rdata. HREADYOUT=1.
  - Minimum latency is 1 wait state; each cycle of sram_gnt=0 adds one.
- Forwarding priority: a write captured in the same cycle as RD_DATA is not forwarded to that read. AHB ordering guarantees that write's address phase came after the read.
- HRDATA holds its last value outside RD_DATA.
- At most one SRAM request per cycle. sram_req never asserts in ERR1/ERR2 for the errored transfer; a pending drain may proceed.

Decomposition:
- Package ahb_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and HSIZE encodings.
  - Bridge state enum: IDLE, RD_REQ, RD_DATA, ERR1, ERR2.
  - Byte-enable function be_from_size(size, addr_lsbs).
- Sub-module ahb_sram_wbuf: one-entry buffer holding valid/addr/be/data. Provides capture, drain-on-grant, and the combinational byte-merge forwarding output.

Test Plan:
- Write 0xDEADBEEF to 0x100, then read 0x100 back-to-back with sram_gnt=1 -> HRDATA=0xDEADBEEF, one wait state, read request precedes drain.
- Byte write HSIZE=0 at 0x103, HWDATA=0xAA000000, over a word holding 0x11223344, then read 0x100 -> sram_be=4'b1000 on drain; HRDATA=0xAA223344 whether forwarded or read from SRAM.
- Read 0x200 with sram_gnt held low 3 cycles -> HREADYOUT low 4 cycles, sram_req held continuously, a single granted read, correct data.
- Read at 0x10000 (MEM_BYTES) and halfword at 0x101 -> each gives HRESP=1 for 2 cycles with HREADYOUT 0 then 1; no sram_req.
- Two back-to-back word writes with sram_gnt low 2 cycles -> second data phase has HREADYOUT=0 until the first drains; both words land in SRAM in order.
- Assert HRESET during RD_REQ with a buffered write -> next cycle HREADYOUT=1, HRESP=0, sram_req=0; the buffered write never reaches SRAM.
